// File: rtl/hpdcache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hpdcache_pkg : HPDcache request payload seen by the prefetch path    |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package hpdcache_pkg;
    localparam int HPDCACHE_ADDR_W = 40;

    typedef struct packed {
        logic [HPDCACHE_ADDR_W-1:0] addr;
        logic [2:0]                 size;
        logic [3:0]                 sid;
    } hpdcache_req_t;
endpackage
`default_nettype wire

// File: rtl/hwpf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hwpf_pkg : shared types for the hardware-prefetch request arbiter    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package hwpf_pkg;
    import hpdcache_pkg::*;

    localparam int HWPF_LINE_OFFSET_W = 6;

    typedef logic [HPDCACHE_ADDR_W-HWPF_LINE_OFFSET_W-1:0] hwpf_line_addr_t;

    typedef enum logic [0:0] {
        HWPF_ARB_IDLE    = 1'b0,
        HWPF_ARB_PRESENT = 1'b1
    } hwpf_arb_state_t;
endpackage
`default_nettype wire

// File: rtl/hwpf_req_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hwpf_req_fifo : sync request FIFO with per-entry valid vector        |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module hwpf_req_fifo
    import hpdcache_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  hpdcache_req_t              data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic                       keep_head_i,
    output hpdcache_req_t              head_o,
    output hpdcache_req_t [DEPTH-1:0]  mem_o,
    output logic [DEPTH-1:0]           valid_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       empty_next_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    hpdcache_req_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             do_push, do_pop;

    assign full_o       = (cnt_q == CNT_W'(DEPTH));
    assign empty_o      = (cnt_q == '0);
    assign do_push      = push_i && !full_o && !flush_i;
    assign do_pop       = pop_i && !empty_o;
    assign head_o       = mem_q[rd_ptr_q];
    assign mem_o        = mem_q;
    assign valid_o      = valid_q;
    assign empty_next_o = (cnt_d == '0);

    always_comb begin
        rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        if (do_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (flush_i) begin
            // Only a head that is already being presented survives a flush.
            valid_d = '0;
            cnt_d   = '0;
            if (keep_head_i && !do_pop && !empty_o) begin
                valid_d[rd_ptr_q] = 1'b1;
                cnt_d             = CNT_W'(1);
            end
            wr_ptr_d = rd_ptr_d + PTR_W'(cnt_d);
        end else begin
            if (do_push) begin
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
                valid_d[wr_ptr_q] = 1'b1;
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end
endmodule
`default_nettype wire

// File: rtl/hwpf_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hwpf_req_arbiter : round-robin prefetch request arbiter into HPDcache|
// | Optional line dedup filter: define HWPF_ARB_DEDUP_EN                 |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module hwpf_req_arbiter
    import hpdcache_pkg::*, hwpf_pkg::*;
#(
    parameter int NUM_PF        = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int LINE_OFFSET_W = HWPF_LINE_OFFSET_W
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic [NUM_PF-1:0]           pf_req_valid_i,
    output logic [NUM_PF-1:0]           pf_req_ready_o,
    input  hpdcache_req_t [NUM_PF-1:0]  pf_req_i,
    input  logic                        cpu_busy_i,
    output logic                        dcache_req_valid_o,
    input  logic                        dcache_req_ready_i,
    output hpdcache_req_t               dcache_req_o,
    output logic [15:0]                 drop_cnt_o
);
    localparam int RR_W = (NUM_PF > 1) ? $clog2(NUM_PF) : 1;

    hwpf_arb_state_t                state_q, state_d;
    logic [RR_W-1:0]                rr_ptr_q, rr_ptr_d, win_idx, cand;
    logic                           win_found, grant, dup_hit, pop, present;
    hpdcache_req_t                  req_sel, fifo_head;
    hpdcache_req_t [FIFO_DEPTH-1:0] fifo_mem;
    logic [FIFO_DEPTH-1:0]          fifo_valid;
    logic                           fifo_full, fifo_empty, fifo_empty_next;

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_PF; k++) begin
            cand = RR_W'((int'(rr_ptr_q) + k) % NUM_PF);
            if (!win_found && pf_req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign grant   = win_found && !fifo_full && !flush_i;
    assign req_sel = pf_req_i[win_idx];

    always_comb begin
        pf_req_ready_o = '0;
        rr_ptr_d       = rr_ptr_q;
        if (grant) begin
            pf_req_ready_o[win_idx] = 1'b1;
            rr_ptr_d = (win_idx == RR_W'(NUM_PF - 1)) ? '0 : win_idx + RR_W'(1);
        end
    end

    assign present            = (state_q == HWPF_ARB_PRESENT);
    assign pop                = present && dcache_req_ready_i;
    assign dcache_req_valid_o = present;
    assign dcache_req_o       = present ? fifo_head : '0;

    hwpf_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (grant && !dup_hit),
        .data_i       (req_sel),
        .pop_i        (pop),
        .flush_i      (flush_i),
        .keep_head_i  (present),
        .head_o       (fifo_head),
        .mem_o        (fifo_mem),
        .valid_o      (fifo_valid),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .empty_next_o (fifo_empty_next)
    );

    // Decisions use next occupancy so a request accepted now is shown next cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HWPF_ARB_IDLE: begin
                if (!fifo_empty_next && !cpu_busy_i) begin
                    state_d = HWPF_ARB_PRESENT;
                end
            end
            HWPF_ARB_PRESENT: begin
                if (dcache_req_ready_i) begin
                    state_d = (!fifo_empty_next && !cpu_busy_i) ? HWPF_ARB_PRESENT
                                                                : HWPF_ARB_IDLE;
                end
            end
            default: state_d = HWPF_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= HWPF_ARB_IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef HWPF_ARB_DEDUP_EN
    localparam int LINE_W = HPDCACHE_ADDR_W - LINE_OFFSET_W;

    logic [LINE_W-1:0] last_line_q;
    logic              last_valid_q;
    logic [15:0]       drop_cnt_q;

    function automatic logic [LINE_W-1:0] line_of(input logic [HPDCACHE_ADDR_W-1:0] a);
        return a[HPDCACHE_ADDR_W-1:LINE_OFFSET_W];
    endfunction

    always_comb begin
        dup_hit = last_valid_q && (last_line_q == line_of(req_sel.addr));
        for (int e = 0; e < FIFO_DEPTH; e++) begin
            if (fifo_valid[e] && (line_of(fifo_mem[e].addr) == line_of(req_sel.addr))) begin
                dup_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_valid_q <= 1'b0;
            last_line_q  <= '0;
            drop_cnt_q   <= '0;
        end else begin
            if (flush_i) begin
                last_valid_q <= 1'b0;
            end else if (pop) begin
                last_valid_q <= 1'b1;
                last_line_q  <= line_of(fifo_head.addr);
            end
            if (grant && dup_hit && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    localparam int unused_line_offset_w = LINE_OFFSET_W;
    logic unused_fifo_view;

    assign unused_fifo_view = ^{fifo_mem, fifo_valid, fifo_empty};
    assign dup_hit          = 1'b0;
    assign drop_cnt_o       = '0;
`endif
endmodule
`default_nettype wire

// File: doc/hwpf_req_arbiter.md
# hwpf_req_arbiter

Collects prefetch requests from one or more hardware prefetchers (next-line and successors) over their valid/ready request ports and forwards them, one per cycle, to the HPDcache prefetch request port. It is the responder side of the prefetcher `arbiter_req_valid_o/arbiter_req_ready_i/arbiter_req_o` handshake. It buffers accepted requests in a small FIFO and yields to demand CPU traffic. Optionally, it filters requests whose cache line is already queued or was just issued.

## Interface
Parameters:
- `NUM_PF`, 2, number of prefetcher request ports
- `FIFO_DEPTH`, 4, buffered requests; power of two, ≥2
- `LINE_OFFSET_W`, 6, byte-offset bits of a cache line (64 B)

Ports:
- `clk_i` in 1: clock
- `rst_i` in 1: reset; synchronous, active-high
- `flush_i` in 1: discard queued requests
- `pf_req_valid_i` in `NUM_PF`: prefetcher request valid
- `pf_req_ready_o` out `NUM_PF`: request accepted this cycle
- `pf_req_i` in `NUM_PF` x `hpdcache_req_t`: prefetcher request payload
- `cpu_busy_i` in 1: demand CPU request occupies the dcache port this cycle
- `dcache_req_valid_o` out 1: request to the dcache valid
- `dcache_req_ready_i` in 1: dcache accepts
- `dcache_req_o` out `hpdcache_req_t`: forwarded request
- `drop_cnt_o` out 16: saturating count of filtered requests

## Operation
- Input grant: round-robin among ports with `pf_req_valid_i` high.
  - Search starts at `rr_ptr`. The lowest index at or after `rr_ptr` (wrapping) wins.
  - At most one `pf_req_ready_o` bit is high per cycle. It is high only for the winner, and only when the FIFO is not full.
  - On a handshake, `rr_ptr` becomes winner+1 mod `NUM_PF`. Otherwise it is unchanged.
- FIFO: each accepted request is pushed unmodified, in order.
  - Full is evaluated on registered occupancy, so there is no push on a full FIFO even if a pop happens the same cycle.
  - Push and pop in the same cycle are legal when not full.
- Output state machine:
  - IDLE: moves to PRESENT when the FIFO is non-empty and `cpu_busy_i` is low. `dcache_req_valid_o` is 0.
  - PRESENT: `dcache_req_valid_o`=1 and `dcache_req_o`=FIFO head.
    - Valid and payload hold stable until `dcache_req_ready_i`. `cpu_busy_i` is ignored once in PRESENT.
    - On handshake: pop, then stay in PRESENT if another entry remains and `cpu_busy_i` is low; otherwise go to IDLE.
- Flush: all entries except the head currently in PRESENT are invalidated. That head completes its handshake normally. `pf_req_ready_o` is 0 during flush.
- Reset: FIFO empty, state IDLE, `rr_ptr`=0, `drop_cnt_o`=0, last-issued register invalid. All outputs are 0.

## Timing
- Request accepted in cycle N: earliest `dcache_req_valid_o` in cycle N+1. There is no combinational path from `pf_req_valid_i` to `dcache_req_valid_o`.
- Full throughput is 1 request/cycle with `dcache_req_ready_i` held high and `cpu_busy_i` low.
- `pf_req_ready_o` depends combinationally on `pf_req_valid_i`, `rr_ptr`, occupancy and `flush_i` only. It never depends on `dcache_req_ready_i`.
- `drop_cnt_o` updates the cycle after the filtered handshake and saturates at 16'hFFFF.

## Configuration
- `HWPF_ARB_DEDUP_EN` defined:
  - The line address of the granted request is `addr[ADDR_W-1:LINE_OFFSET_W]`. It is compared against every valid FIFO entry and against the last-issued line register.
  - The last-issued register is loaded on each output handshake and invalidated by flush and reset.
  - On a match the request is still accepted (`pf_req_ready_o`=1), but it is not pushed, and `drop_cnt_o` increments.
- `HWPF_ARB_DEDUP_EN` undefined: no comparators; every accepted request is pushed; `drop_cnt_o` is tied to 0.

## Structure
- `hpdcache_req_t` comes from `hpdcache_pkg`.
- Shared package `hwpf_pkg` holds:
  - the `hwpf_arb_state_t` enum (IDLE, PRESENT)
  - the `HWPF_LINE_OFFSET_W` constant
  - the `hwpf_line_addr_t` typedef
- One sub-module: `hwpf_req_fifo`, a parameterized sync FIFO with full/empty and a per-entry valid vector. The valid vector feeds dedup and flush.

## Test plan
- Single port 0, addr 40'hCAFE0040, ready high → `dcache_req_valid_o`=1 with addr 40'hCAFE0040 exactly one cycle later, then IDLE.
- Ports 0 and 1 both valid for 2 cycles (0xCAFE0040, 0xBEEF0080) → accepted order port0 then port1. Output in that order; `rr_ptr` wraps to 0.
- `dcache_req_ready_i`=0, 5 requests pushed → the 5th sees `pf_req_ready_o`=0 until one pop. The presented payload stays 40'hCAFE0040 throughout the stall.
- `cpu_busy_i`=1 with a non-empty FIFO → valid stays 0. `cpu_busy_i` rising while in PRESENT → valid stays 1 until handshake.
- 3 entries queued, head presented, `flush_i` pulse → the head completes on ready; the remaining 2 are never issued. Reset mid-PRESENT → all outputs 0 the next cycle.
- With `HWPF_ARB_DEDUP_EN`: 0xCAFE0040 issued, then 0xCAFE0050 and 0xCAFE0040 offered → both accepted, neither issued, `drop_cnt_o`=2. Without the macro: both issued, `drop_cnt_o`=0.
